// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM-stage
// data port: data wins, but a streak counter bounds how long a waiting fetch starves.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              if_stall_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    state_e              state_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_ack_q;
    logic                dm_ack_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    logic if_live;
    logic dm_live;
    logic dm_grant;

    // A requester is still asserting during its ack cycle, so it must not be re-granted then.
    assign if_live  = if_req_i & ~if_ack_q;
    assign dm_live  = (dm_read_i | dm_write_i) & ~dm_ack_q;
    assign dm_grant = dm_live & (~if_live | (streak_q < STREAK_MAX));

    assign streak_d = !if_live                 ? '0 :
                      (streak_q < STREAK_MAX)  ? streak_q + STREAK_W'(1) :
                                                 streak_q;

    assign if_stall_o = if_req_i & ~if_ack_q;
    assign dm_stall_o = (dm_read_i | dm_write_i) & ~dm_ack_q;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    // Arbitration in IDLE only; a BUSY state holds the memory bus until mem_ack_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dm_grant) begin
                        state_q     <= BUSY_DM;
                        streak_q    <= streak_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_write_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                    end else if (if_live) begin
                        state_q    <= BUSY_IF;
                        streak_q   <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr_i;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack_i) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= mem_rdata_i;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack_i) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        dm_ack_q  <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, load, store, contention, streak limit
// and slow-memory scenarios against hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        if_stall_o;
    logic        dm_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int checks = 0;
    int errors = 0;

    logic        resp_en;
    int          resp_lat;
    logic [31:0] resp_rdata;
    logic        resp_ack;
    logic        man_ack;
    int          wait_cnt;

    assign mem_ack_i   = resp_ack | man_ack;
    assign mem_rdata_i = resp_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .if_stall_o  (if_stall_o),
        .dm_stall_o  (dm_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    // Memory model: acks resp_lat cycles after the cycle mem_req_o first appears.
    initial begin
        resp_ack = 1'b0;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (resp_en && mem_req_o) begin
                if (wait_cnt >= resp_lat) begin
                    resp_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_dm, input int max, output int n);
        bit done;
        done = 1'b0;
        n    = -1;
        for (int i = 1; i <= max; i++) begin
            if (!done) begin
                step();
                if ((is_dm ? dm_ack_o : if_ack_o) === 1'b1) begin
                    n    = i;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o});
        end
        rst_n = 1'b1;
        step();
        dm_read_i = 1'b1;
        dm_addr_i = 32'h300;
        step();
        step();
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
            errors++;
            $display("FAIL reset_busy_setup: got req %b addr %h expected 1 00000300", mem_req_o, mem_addr_o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || dm_ack_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got req %b ack %b addr %h expected 0 0 0", mem_req_o, dm_ack_o, mem_addr_o);
        end
        dm_read_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        resp_rdata = 32'hBAD0BAD0;
        man_ack    = 1'b1;
        step();
        man_ack = 1'b0;
        step();
        checks++;
        if ({mem_req_o, if_ack_o, dm_ack_o} !== 3'b000 || dm_rdata_o !== 32'h0 || if_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_late_ack: got req/ifack/dmack %b dm %h if %h expected 000 0 0",
                     {mem_req_o, if_ack_o, dm_ack_o}, dm_rdata_o, if_rdata_o);
        end
    endtask

    task automatic test_single_load();
        int n;
        resp_en    = 1'b1;
        resp_lat   = 2;
        resp_rdata = 32'hDEADBEEF;
        dm_read_i  = 1'b1;
        dm_addr_i  = 32'h100;
        #1;
        checks++;
        if (dm_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL load_stall: got %b expected 1", dm_stall_o);
        end
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL load_launch: got req %b we %b addr %h expected 1 0 00000100", mem_req_o, mem_we_o, mem_addr_o);
        end
        wait_ack(1'b1, 20, n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL load_latency: got %0d expected 3", n);
        end
        checks++;
        if (dm_rdata_o !== 32'hDEADBEEF || dm_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL load_data: got %h stall %b req %b expected deadbeef 0 0", dm_rdata_o, dm_stall_o, mem_req_o);
        end
        dm_read_i = 1'b0;
        step();
        checks++;
        if (dm_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL load_ack_pulse: got ack %b req %b expected 0 0", dm_ack_o, mem_req_o);
        end
    endtask

    task automatic test_store();
        int n;
        resp_lat   = 0;
        resp_rdata = 32'h12345678;
        dm_write_i = 1'b1;
        dm_addr_i  = 32'h20;
        dm_wdata_i = 32'h55;
        step();
        checks++;
        if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'h55 || mem_addr_o !== 32'h20) begin
            errors++;
            $display("FAIL store_launch: got we %b wdata %h addr %h expected 1 00000055 00000020", mem_we_o, mem_wdata_o, mem_addr_o);
        end
        wait_ack(1'b1, 20, n);
        checks++;
        if (n !== 1 || dm_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_ack: got latency %0d rdata %h expected 1 deadbeef", n, dm_rdata_o);
        end
        dm_write_i = 1'b0;
        step();
        checks++;
        if (dm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL store_ack_pulse: got %b expected 0", dm_ack_o);
        end
        dm_read_i  = 1'b1;
        dm_write_i = 1'b1;
        dm_addr_i  = 32'h24;
        dm_wdata_i = 32'hA5A5;
        step();
        checks++;
        if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hA5A5) begin
            errors++;
            $display("FAIL rw_both_we: got we %b wdata %h expected 1 0000a5a5", mem_we_o, mem_wdata_o);
        end
        wait_ack(1'b1, 20, n);
        checks++;
        if (n !== 1 || dm_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rw_both_rdata: got latency %0d rdata %h expected 1 deadbeef", n, dm_rdata_o);
        end
        dm_read_i  = 1'b0;
        dm_write_i = 1'b0;
        step();
    endtask

    task automatic test_contention();
        int  n;
        int  stall_bad;
        bit  done;
        resp_lat   = 1;
        resp_rdata = 32'hCAFE0001;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h400;
        dm_read_i  = 1'b1;
        dm_addr_i  = 32'h104;
        step();
        checks++;
        if (mem_addr_o !== 32'h104 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL contend_dm_first: got addr %h we %b expected 00000104 0", mem_addr_o, mem_we_o);
        end
        stall_bad = (if_stall_o !== 1'b1) ? 1 : 0;
        n    = -1;
        done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!done) begin
                step();
                if (if_stall_o !== 1'b1) stall_bad++;
                if (dm_ack_o === 1'b1) begin
                    n    = i;
                    done = 1'b1;
                end
            end
        end
        checks++;
        if (n !== 2 || mem_req_o !== 1'b0 || dm_rdata_o !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL contend_dm_ack: got latency %0d req %b rdata %h expected 2 0 cafe0001", n, mem_req_o, dm_rdata_o);
        end
        dm_read_i  = 1'b0;
        resp_rdata = 32'hCAFE0002;
        step();
        if (if_stall_o !== 1'b1) stall_bad++;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL contend_if_next: got req %b addr %h we %b expected 1 00000400 0", mem_req_o, mem_addr_o, mem_we_o);
        end
        wait_ack(1'b0, 20, n);
        checks++;
        if (n !== 2 || if_rdata_o !== 32'hCAFE0002 || if_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL contend_if_ack: got latency %0d rdata %h stall %b expected 2 cafe0002 0", n, if_rdata_o, if_stall_o);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL contend_if_stall: got %0d low-stall cycles expected 0", stall_bad);
        end
        if_req_i = 1'b0;
        step();
        checks++;
        if (if_ack_o !== 1'b0 || dm_rdata_o !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL contend_if_pulse: got ack %b dm_rdata %h expected 0 cafe0001", if_ack_o, dm_rdata_o);
        end
    endtask

    // Both ports raise together each round; the fetch is redirected while DM is served.
    task automatic test_starvation();
        int n;
        resp_lat   = 0;
        resp_rdata = 32'h0;
        for (int r = 0; r < 4; r++) begin
            if_req_i  = 1'b1;
            if_addr_i = 32'h800;
            dm_read_i = 1'b1;
            dm_addr_i = 32'h200 + 32'(r * 4);
            step();
            checks++;
            if (mem_addr_o !== 32'h200 + 32'(r * 4)) begin
                errors++;
                $display("FAIL starve_dm_round%0d: got addr %h expected %h", r, mem_addr_o, 32'h200 + 32'(r * 4));
            end
            if_req_i = 1'b0;
            wait_ack(1'b1, 20, n);
            dm_read_i = 1'b0;
            step();
        end
        if_req_i  = 1'b1;
        dm_read_i = 1'b1;
        dm_addr_i = 32'h210;
        step();
        checks++;
        if (mem_addr_o !== 32'h800 || mem_we_o !== 1'b0 || dm_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_if_grant: got addr %h we %b dm_stall %b expected 00000800 0 1", mem_addr_o, mem_we_o, dm_stall_o);
        end
        wait_ack(1'b0, 20, n);
        if_req_i = 1'b0;
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h210) begin
            errors++;
            $display("FAIL starve_dm_resume: got req %b addr %h expected 1 00000210", mem_req_o, mem_addr_o);
        end
        wait_ack(1'b1, 20, n);
        dm_read_i = 1'b0;
        step();
        if_req_i  = 1'b1;
        dm_read_i = 1'b1;
        dm_addr_i = 32'h214;
        step();
        checks++;
        if (mem_addr_o !== 32'h214) begin
            errors++;
            $display("FAIL starve_streak_clear: got addr %h expected 00000214", mem_addr_o);
        end
        if_req_i = 1'b0;
        wait_ack(1'b1, 20, n);
        dm_read_i = 1'b0;
        step();
    endtask

    task automatic test_slow_memory();
        int n;
        int unstable;
        bit done;
        resp_lat   = 10;
        resp_rdata = 32'h0BADF00D;
        dm_write_i = 1'b1;
        dm_addr_i  = 32'h440;
        dm_wdata_i = 32'h77;
        step();
        if_req_i  = 1'b1;
        if_addr_i = 32'h900;
        unstable  = 0;
        n         = -1;
        done      = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (!done) begin
                step();
                if (dm_ack_o === 1'b1) begin
                    n    = i;
                    done = 1'b1;
                end else if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h440 || mem_we_o !== 1'b1 ||
                             mem_wdata_o !== 32'h77 || if_stall_o !== 1'b1) begin
                    unstable++;
                end
            end
        end
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL slow_latency: got %0d expected 11", n);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL slow_stable: got %0d unstable cycles expected 0", unstable);
        end
        dm_write_i = 1'b0;
        resp_lat   = 0;
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h900 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL slow_if_after: got req %b addr %h we %b expected 1 00000900 0", mem_req_o, mem_addr_o, mem_we_o);
        end
        wait_ack(1'b0, 20, n);
        checks++;
        if (n !== 1 || if_rdata_o !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL slow_if_ack: got latency %0d rdata %h expected 1 0badf00d", n, if_rdata_o);
        end
        if_req_i = 1'b0;
        step();
    endtask

    initial begin
        rst_n      = 1'b1;
        if_req_i   = 1'b0;
        if_addr_i  = 32'h0;
        dm_read_i  = 1'b0;
        dm_write_i = 1'b0;
        dm_addr_i  = 32'h0;
        dm_wdata_i = 32'h0;
        resp_en    = 1'b0;
        resp_lat   = 0;
        resp_rdata = 32'h0;
        man_ack    = 1'b0;
        #1;
        rst_n = 1'b0;
        step();
        step();
        test_reset();
        test_single_load();
        test_store();
        test_contention();
        test_starvation();
        test_slow_memory();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
